// File: rtl/codec_to_fft_prescaler_pkg.sv
// Shared constants, types and helpers for the codec -> FFT prescaler and the
// matching post-IFFT rescaling glue.
package codec_to_fft_prescaler_pkg;

    localparam int DATA_W    = 18;
    localparam int LOG_DEPTH = 9;
    localparam int SCALE_W   = 4;
    localparam int MAX_SHIFT = 15;
    localparam int LZC_W     = $clog2(DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              start;
        logic              last;
    } beat_t;

    localparam beat_t BEAT_NONE = '{data: {DATA_W{1'b0}}, start: 1'b0, last: 1'b0};

    // Leading-zero count of a magnitude with the sign bit already stripped.
    function automatic logic [LZC_W-1:0] lzc(input logic [DATA_W-2:0] v);
        logic [LZC_W-1:0] cnt;
        logic             found;
        cnt   = LZC_W'(DATA_W - 1);
        found = 1'b0;
        for (int i = DATA_W - 2; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = LZC_W'(DATA_W - 2 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/codec_to_fft_prescaler_if.sv
// Codec sample input, FFT streaming output and frame side-band signals.
interface codec_to_fft_prescaler_if;
    import codec_to_fft_prescaler_pkg::*;

    logic [DATA_W-1:0]  from_codec_data;
    logic               from_codec_ready;
    logic               to_fft_ready;
    logic [DATA_W-1:0]  to_fft_data_real;
    logic [DATA_W-1:0]  to_fft_data_imag;
    logic               to_fft_valid;
    logic               to_fft_start;
    logic               to_fft_last;
    logic [SCALE_W-1:0] input_scaling;
    logic               frame_dropped;

    modport slave (
        input  from_codec_data, from_codec_ready, to_fft_ready,
        output to_fft_data_real, to_fft_data_imag, to_fft_valid,
        output to_fft_start, to_fft_last, input_scaling, frame_dropped
    );

    modport master (
        output from_codec_data, from_codec_ready, to_fft_ready,
        input  to_fft_data_real, to_fft_data_imag, to_fft_valid,
        input  to_fft_start, to_fft_last, input_scaling, frame_dropped
    );

endinterface

// File: rtl/codec_to_fft_prescaler_frame_buffer.sv
// Ping-pong frame store: bank bit in the address MSB, synchronous write,
// one-cycle registered read.
module prescale_frame_buffer
    import codec_to_fft_prescaler_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = LOG_DEPTH + 1
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port, data valid the cycle after rd_en_i.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/codec_to_fft_prescaler.sv
// Collects codec samples into ping-pong frames, finds each frame's headroom and
// streams it to the FFT left-shifted by that headroom, reporting the shift.
module codec_to_fft_prescaler #(
    parameter int LOG_DEPTH = codec_to_fft_prescaler_pkg::LOG_DEPTH,
    parameter int MAX_SHIFT = codec_to_fft_prescaler_pkg::MAX_SHIFT
) (
    input logic                     clock,
    input logic                     reset,
    codec_to_fft_prescaler_if.slave bus
);
    import codec_to_fft_prescaler_pkg::*;

    localparam logic [LOG_DEPTH-1:0] LAST_ADDR = {LOG_DEPTH{1'b1}};

    // Write side state
    logic [LOG_DEPTH-1:0] wr_addr_q, wr_addr_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [DATA_W-1:0]    peak_acc_q, peak_acc_d;
    logic                 rd_full_q, rd_full_d;
    logic [SCALE_W-1:0]   rd_shift_q, rd_shift_d;
    logic                 frame_dropped_q, frame_dropped_d;

    // Read side state
    rd_state_e            state_q;
    logic [LOG_DEPTH-1:0] rd_addr_q;
    logic                 issued_all_q;
    logic                 inflight_q, inflight_start_q, inflight_last_q;
    beat_t                head_q, head_d, tail_q, tail_d, push_beat_s;
    logic                 head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                 head_load_s;
    logic [SCALE_W-1:0]   input_scaling_q;

    logic                 wr_en_s, wrap_s, bank_free_s;
    logic [DATA_W-1:0]    mag_s, peak_new_s, rd_data_s;
    logic [LZC_W-1:0]     lzc_s;
    logic [SCALE_W-1:0]   shift_s;
    logic                 pop_s, rd_free_s, issue_s;
    logic [1:0]           occ_s;

    prescale_frame_buffer #(
        .WIDTH  (DATA_W),
        .ADDR_W (LOG_DEPTH + 1)
    ) u_buf (
        .clk_i     (clock),
        .wr_en_i   (wr_en_s),
        .wr_addr_i ({wr_bank_q, wr_addr_q}),
        .wr_data_i (bus.from_codec_data),
        .rd_en_i   (issue_s),
        .rd_addr_i ({~wr_bank_q, rd_addr_q}),
        .rd_data_o (rd_data_s)
    );

    // One's-complement magnitude keeps -2**(N-1) at full scale, so it never gets shifted.
    assign wr_en_s     = bus.from_codec_ready;
    assign mag_s       = bus.from_codec_data ^ {DATA_W{bus.from_codec_data[DATA_W-1]}};
    assign peak_new_s  = peak_acc_q | mag_s;
    assign wrap_s      = wr_en_s && (wr_addr_q == LAST_ADDR);
    assign lzc_s       = lzc(peak_new_s[DATA_W-2:0]);
    assign shift_s     = (lzc_s > LZC_W'(MAX_SHIFT)) ? SCALE_W'(MAX_SHIFT) : lzc_s[SCALE_W-1:0];
    assign pop_s       = head_vld_q && bus.to_fft_ready;
    assign rd_free_s   = pop_s && head_q.last;
    assign bank_free_s = !rd_full_q || rd_free_s;

    // Skid occupancy counts the BRAM read still in flight.
    assign occ_s   = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, inflight_q};
    assign issue_s = (state_q == ST_STREAM) && !issued_all_q &&
                     ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));

    // Write counter, peak accumulation, bank swap or frame drop at wrap.
    always_comb begin
        wr_addr_d       = wr_addr_q;
        wr_bank_d       = wr_bank_q;
        peak_acc_d      = peak_acc_q;
        rd_shift_d      = rd_shift_q;
        frame_dropped_d = 1'b0;
        if (wr_en_s) begin
            wr_addr_d = wr_addr_q + LOG_DEPTH'(1);
            if (wrap_s) begin
                peak_acc_d = {DATA_W{1'b0}};
                if (bank_free_s) begin
                    wr_bank_d  = ~wr_bank_q;
                    rd_shift_d = shift_s;
                end else begin
                    frame_dropped_d = 1'b1;
                end
            end else begin
                peak_acc_d = peak_new_s;
            end
        end else begin
            wr_addr_d = wr_addr_q;
        end
        if (wrap_s && bank_free_s) begin
            rd_full_d = 1'b1;
        end else if (rd_free_s) begin
            rd_full_d = 1'b0;
        end else begin
            rd_full_d = rd_full_q;
        end
    end

    // Write side registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr_q       <= {LOG_DEPTH{1'b0}};
            wr_bank_q       <= 1'b0;
            peak_acc_q      <= {DATA_W{1'b0}};
            rd_full_q       <= 1'b0;
            rd_shift_q      <= {SCALE_W{1'b0}};
            frame_dropped_q <= 1'b0;
        end else begin
            wr_addr_q       <= wr_addr_d;
            wr_bank_q       <= wr_bank_d;
            peak_acc_q      <= peak_acc_d;
            rd_full_q       <= rd_full_d;
            rd_shift_q      <= rd_shift_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    // Read FSM: address generation and tagging of the in-flight BRAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rd_addr_q        <= {LOG_DEPTH{1'b0}};
            issued_all_q     <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_start_q <= 1'b0;
            inflight_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inflight_q   <= 1'b0;
                    rd_addr_q    <= {LOG_DEPTH{1'b0}};
                    issued_all_q <= 1'b0;
                    if (rd_full_q) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    inflight_q       <= issue_s;
                    inflight_start_q <= (rd_addr_q == {LOG_DEPTH{1'b0}});
                    inflight_last_q  <= (rd_addr_q == LAST_ADDR);
                    if (issue_s) begin
                        rd_addr_q <= rd_addr_q + LOG_DEPTH'(1);
                        if (rd_addr_q == LAST_ADDR) begin
                            issued_all_q <= 1'b1;
                        end
                    end
                    if (rd_free_s) begin
                        state_q      <= ST_IDLE;
                        rd_addr_q    <= {LOG_DEPTH{1'b0}};
                        issued_all_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry skid buffer; head is the registered output beat.
    always_comb begin
        push_beat_s.data  = rd_data_s << rd_shift_q;
        push_beat_s.start = inflight_start_q;
        push_beat_s.last  = inflight_last_q;
        head_d      = head_q;
        tail_d      = tail_q;
        head_vld_d  = head_vld_q;
        tail_vld_d  = tail_vld_q;
        head_load_s = 1'b0;
        case ({pop_s, inflight_q})
            2'b01: begin
                if (!head_vld_q) begin
                    head_d      = push_beat_s;
                    head_vld_d  = 1'b1;
                    head_load_s = 1'b1;
                end else begin
                    tail_d     = push_beat_s;
                    tail_vld_d = 1'b1;
                end
            end
            2'b10: begin
                head_d      = tail_vld_q ? tail_q : BEAT_NONE;
                head_vld_d  = tail_vld_q;
                tail_d      = BEAT_NONE;
                tail_vld_d  = 1'b0;
                head_load_s = tail_vld_q;
            end
            2'b11: begin
                head_load_s = 1'b1;
                if (tail_vld_q) begin
                    head_d = tail_q;
                    tail_d = push_beat_s;
                end else begin
                    head_d = push_beat_s;
                end
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    // Skid buffer and reported-scaling registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q          <= BEAT_NONE;
            tail_q          <= BEAT_NONE;
            head_vld_q      <= 1'b0;
            tail_vld_q      <= 1'b0;
            input_scaling_q <= {SCALE_W{1'b0}};
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            if (head_load_s && head_d.start) begin
                input_scaling_q <= rd_shift_q;
            end
        end
    end

    assign bus.to_fft_data_real = head_q.data;
    assign bus.to_fft_data_imag = {DATA_W{1'b0}};
    assign bus.to_fft_valid     = head_vld_q;
    assign bus.to_fft_start     = head_q.start;
    assign bus.to_fft_last      = head_q.last;
    assign bus.input_scaling    = input_scaling_q;
    assign bus.frame_dropped    = frame_dropped_q;

endmodule

// File: tb/tb_codec_to_fft_prescaler.sv
// Directed bench for codec_to_fft_prescaler with 8-sample frames.
module tb_codec_to_fft_prescaler;
    import codec_to_fft_prescaler_pkg::*;

    typedef logic signed [17:0] frame_t [8];

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   drop_cnt = 0;
    int   ready_mode = 0;
    logic rdy_fixed = 1'b0;

    logic signed [17:0] q_data[$];
    logic [17:0]        q_imag[$];
    logic               q_start[$];
    logic               q_last[$];
    logic [3:0]         q_scale[$];

    codec_to_fft_prescaler_if bus();

    codec_to_fft_prescaler #(.LOG_DEPTH(3), .MAX_SHIFT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_shift(input frame_t xs);
        int peak = 0;
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            int v = 32'(xs[i]);
            peak = peak | ((v < 0) ? (-v - 1) : v);
        end
        while (s < 15 && peak < (1 << (16 - s))) s++;
        return s;
    endfunction

    // ready driver
    initial begin
        int ph = 0;
        bus.to_fft_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: bus.to_fft_ready = rdy_fixed;
                1: begin
                    bus.to_fft_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: bus.to_fft_ready = ($urandom_range(0, 9) < 7);
                default: bus.to_fft_ready = 1'b0;
            endcase
        end
    end

    // monitor: records transfers, counts drops, checks stability while stalled
    initial begin
        logic        stall = 1'b0;
        logic [17:0] sd = 18'd0;
        logic        ss = 1'b0;
        logic        sl = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.frame_dropped === 1'b1) drop_cnt++;
            if (stall && bus.to_fft_valid === 1'b1) begin
                check("stall_data", 32'($signed(bus.to_fft_data_real)), 32'($signed(sd)));
                check("stall_start", 32'(bus.to_fft_start), 32'(ss));
                check("stall_last", 32'(bus.to_fft_last), 32'(sl));
            end
            if (bus.to_fft_valid === 1'b1 && bus.to_fft_ready === 1'b1) begin
                q_data.push_back($signed(bus.to_fft_data_real));
                q_imag.push_back(bus.to_fft_data_imag);
                q_start.push_back(bus.to_fft_start);
                q_last.push_back(bus.to_fft_last);
                q_scale.push_back(bus.input_scaling);
            end
            stall = (bus.to_fft_valid === 1'b1) && (bus.to_fft_ready === 1'b0);
            sd = bus.to_fft_data_real;
            ss = bus.to_fft_start;
            sl = bus.to_fft_last;
        end
    end

    task automatic send_sample(input logic signed [17:0] x);
        @(posedge clock);
        #1;
        bus.from_codec_data  = x;
        bus.from_codec_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.from_codec_ready = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic send_frame(input frame_t xs);
        for (int i = 0; i < 8; i++) send_sample(xs[i]);
    endtask

    task automatic clear_queues();
        q_data.delete(); q_imag.delete(); q_start.delete(); q_last.delete(); q_scale.delete();
    endtask

    task automatic expect_frame(input frame_t xs, input int sh, input string tag);
        int t = 0;
        logic signed [17:0] e;
        while (q_data.size() < 8 && t < 3000) begin
            @(posedge clock);
            t++;
        end
        if (q_data.size() < 8) begin
            check({tag, "_beats"}, 32'(q_data.size()), 32'd8);
            clear_queues();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            e = xs[i] <<< sh;
            check($sformatf("%s_b%0d_data", tag, i), 32'(q_data.pop_front()), 32'(e));
            check($sformatf("%s_b%0d_imag", tag, i), 32'(q_imag.pop_front()), 32'd0);
            check($sformatf("%s_b%0d_start", tag, i), 32'(q_start.pop_front()), 32'(i == 0));
            check($sformatf("%s_b%0d_last", tag, i), 32'(q_last.pop_front()), 32'(i == 7));
            check($sformatf("%s_b%0d_scale", tag, i), 32'(q_scale.pop_front()), 32'(sh));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.to_fft_valid), 32'd0);
        check({tag, "_start"}, 32'(bus.to_fft_start), 32'd0);
        check({tag, "_last"}, 32'(bus.to_fft_last), 32'd0);
        check({tag, "_real"}, 32'(bus.to_fft_data_real), 32'd0);
        check({tag, "_imag"}, 32'(bus.to_fft_data_imag), 32'd0);
        check({tag, "_scale"}, 32'(bus.input_scaling), 32'd0);
        check({tag, "_drop"}, 32'(bus.frame_dropped), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_zero_outputs(tag);
        reset = 1'b0;
        clear_queues();
    endtask

    initial begin
        frame_t fa, fz, fm, ft, f1, f2, f3, f4, fy, fx, fr;
        int d0;
        int t;
        int shifts[6];
        frame_t rf[6];

        bus.from_codec_data  = 18'sd0;
        bus.from_codec_ready = 1'b0;
        fa = '{18'sd1, -18'sd2, 18'sd3, -18'sd4, 18'sd5, -18'sd6, 18'sd7, -18'sd8};
        fz = '{default: 18'sd0};
        fm = '{-18'sd131072, 18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd6, 18'sd7};
        ft = '{18'sd10, -18'sd20, 18'sd30, -18'sd40, 18'sd50, -18'sd60, 18'sd70, -18'sd80};
        f1 = '{18'sd1000, -18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd6, 18'sd7};
        f2 = '{default: 18'sd5};
        f3 = '{default: 18'sd0};
        f4 = '{18'sd256, -18'sd256, 18'sd0, 18'sd1, -18'sd1, 18'sd2, -18'sd2, 18'sd3};
        fy = '{18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd6, 18'sd7, 18'sd8};
        fx = '{default: -18'sd131072};

        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        rdy_fixed = 1'b1;
        send_frame(fa);
        expect_frame(fa, 14, "alt");
        send_frame(fz);
        expect_frame(fz, 15, "zero");
        send_frame(fm);
        expect_frame(fm, 0, "minval");

        ready_mode = 1;
        send_frame(ft);
        expect_frame(ft, 10, "toggle");
        ready_mode = 0;

        // three frames against a stalled FFT: two are dropped
        rdy_fixed = 1'b0;
        repeat (4) @(posedge clock);
        d0 = drop_cnt;
        send_frame(f1);
        send_frame(f2);
        send_frame(f3);
        repeat (10) @(posedge clock);
        check("drop_count", 32'(drop_cnt - d0), 32'd2);
        check("drop_no_beats", 32'(q_data.size()), 32'd0);
        check("drop_head_valid", 32'(bus.to_fft_valid), 32'd1);
        check("drop_head_start", 32'(bus.to_fft_start), 32'd1);
        check("drop_head_scale", 32'(bus.input_scaling), 32'd7);
        rdy_fixed = 1'b1;
        expect_frame(f1, 7, "held");
        send_frame(f4);
        expect_frame(f4, 8, "after_drop");
        check("drop_count_final", 32'(drop_cnt - d0), 32'd2);

        // reset during a fill
        for (int i = 0; i < 5; i++) send_sample(fx[i]);
        pulse_reset("rst_fill");
        send_frame(fy);
        expect_frame(fy, 13, "post_fill_rst");
        repeat (20) @(posedge clock);
        check("post_fill_rst_extra", 32'(q_data.size()), 32'd0);

        // reset while a frame is stalled in the stream
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clock);
        send_frame(ft);
        t = 0;
        while (bus.to_fft_valid !== 1'b1 && t < 100) begin
            @(posedge clock);
            t++;
        end
        check("mid_stream_valid", 32'(bus.to_fft_valid), 32'd1);
        pulse_reset("rst_stream");
        rdy_fixed = 1'b1;
        send_frame(fa);
        expect_frame(fa, 14, "post_stream_rst");
        repeat (20) @(posedge clock);
        check("post_stream_rst_extra", 32'(q_data.size()), 32'd0);

        // back-to-back random frames with random ready
        ready_mode = 2;
        d0 = drop_cnt;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) begin
                logic signed [17:0] r;
                r = 18'($urandom);
                fr[i] = r >>> $urandom_range(0, 17);
            end
            rf[f] = fr;
            shifts[f] = ref_shift(fr);
            send_frame(fr);
        end
        for (int f = 0; f < 6; f++) begin
            expect_frame(rf[f], shifts[f], $sformatf("rnd%0d", f));
        end
        check("rnd_no_drop", 32'(drop_cnt - d0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
